// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller: FSM state encoding and coin codes.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } vend_state_e;

    localparam logic [1:0] COIN_C0      = 2'd0;
    localparam logic [1:0] COIN_C1      = 2'd1;
    localparam logic [1:0] COIN_C2      = 2'd2;
    localparam logic [1:0] COIN_INVALID = 2'd3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/vend_ctrl_if.sv
// Coin-acceptor / dispenser / hopper signal bundle. slave = controller view, master = environment view.
interface vend_ctrl_if #(
    parameter int CREDIT_W = 6
);
    logic                coin_valid;
    logic [1:0]          coin_code;
    logic                coin_ready;
    logic                coin_reject;
    logic                cancel;
    logic                product;
    logic [CREDIT_W-1:0] credit;
    logic                change_valid;
    logic [CREDIT_W-1:0] change_amt;
    logic                change_ready;

    modport slave (
        input  coin_valid, coin_code, cancel, change_ready,
        output coin_ready, coin_reject, product, credit, change_valid, change_amt
    );

    modport master (
        output coin_valid, coin_code, cancel, change_ready,
        input  coin_ready, coin_reject, product, credit, change_valid, change_amt
    );
endinterface

// File: rtl/vend_coin_decode.sv
// Combinational coin-code decoder: maps a 2-bit coin code to an accept flag and credit value.
module vend_coin_decode
    import vend_pkg::*;
#(
    parameter int CREDIT_W  = 6,
    parameter int COIN0_VAL = 5,
    parameter int COIN1_VAL = 10,
    parameter int COIN2_VAL = 20
) (
    input  logic [1:0]          i_code,
    output logic                o_valid,
    output logic [CREDIT_W-1:0] o_value
);

    always_comb begin
        o_valid = 1'b1;
        o_value = '0;
        case (i_code)
            COIN_C0: o_value = CREDIT_W'(COIN0_VAL);
            COIN_C1: o_value = CREDIT_W'(COIN1_VAL);
            COIN_C2: o_value = CREDIT_W'(COIN2_VAL);
            default: o_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/vend_ctrl.sv
// Coin-operated vending controller: credit accumulation, vend pulse, change handshake, cancel refund.
// Optional ACCUM inactivity auto-refund enabled by defining VEND_TIMEOUT_EN.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE       = 20,
    parameter int COIN0_VAL   = 5,
    parameter int COIN1_VAL   = 10,
    parameter int COIN2_VAL   = 20,
    parameter int CREDIT_W    = 6,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic   sys_clk,
    input  logic   sys_rst_n,
    vend_ctrl_if.slave bus
);

    localparam int MAX_COIN = max3(COIN0_VAL, COIN1_VAL, COIN2_VAL);

    // Worst-case sum is (PRICE-1) + largest coin; it must fit without wrapping.
    if ((2 ** CREDIT_W) <= (PRICE - 1 + MAX_COIN)) begin : g_bad_width
        $error("vend_ctrl: CREDIT_W too narrow for PRICE and coin values");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("vend_ctrl: TIMEOUT_CYC must be at least 2");
    end

    vend_state_e         r_state, w_next;
    logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
    logic [CREDIT_W-1:0] r_change_amt, w_change_nxt;
    logic                r_product, r_reject, r_change_valid;
    logic                w_reject_nxt, w_coin_acc, w_tmo_hit, w_coin_ready;
    logic                w_dec_valid;
    logic [CREDIT_W-1:0] w_dec_value, w_sum, w_excess;

    vend_coin_decode #(
        .CREDIT_W  (CREDIT_W),
        .COIN0_VAL (COIN0_VAL),
        .COIN1_VAL (COIN1_VAL),
        .COIN2_VAL (COIN2_VAL)
    ) u_dec (
        .i_code  (bus.coin_code),
        .o_valid (w_dec_valid),
        .o_value (w_dec_value)
    );

    assign w_sum        = r_credit + w_dec_value;
    assign w_excess     = r_credit - CREDIT_W'(PRICE);
    assign w_coin_ready = sys_rst_n & ((r_state == IDLE) | (r_state == ACCUM));

    always_comb begin
        w_next       = r_state;
        w_credit_nxt = r_credit;
        w_change_nxt = r_change_amt;
        w_reject_nxt = 1'b0;
        w_coin_acc   = 1'b0;
        case (r_state)
            IDLE, ACCUM: begin
                // Cancel outranks a simultaneous coin, which is handed back.
                if ((r_state == ACCUM) && bus.cancel) begin
                    w_next       = CHANGE;
                    w_change_nxt = r_credit;
                    w_credit_nxt = '0;
                    w_reject_nxt = bus.coin_valid;
                end else if (bus.coin_valid && w_dec_valid) begin
                    w_coin_acc   = 1'b1;
                    w_credit_nxt = w_sum;
                    w_next       = (w_sum >= CREDIT_W'(PRICE)) ? VEND : ACCUM;
                end else if (bus.coin_valid) begin
                    w_reject_nxt = 1'b1;
                end else if (w_tmo_hit) begin
                    w_next       = CHANGE;
                    w_change_nxt = r_credit;
                    w_credit_nxt = '0;
                end
            end
            VEND: begin
                w_change_nxt = w_excess;
                w_credit_nxt = '0;
                w_next       = (r_credit > CREDIT_W'(PRICE)) ? CHANGE : IDLE;
            end
            CHANGE: begin
                if (bus.change_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state        <= IDLE;
            r_credit       <= '0;
            r_change_amt   <= '0;
            r_product      <= 1'b0;
            r_reject       <= 1'b0;
            r_change_valid <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_credit       <= w_credit_nxt;
            r_change_amt   <= w_change_nxt;
            r_product      <= (w_next == VEND);
            r_reject       <= w_reject_nxt;
            r_change_valid <= (w_next == CHANGE);
        end
    end

`ifdef VEND_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC);
    logic [TMO_W-1:0] r_tmo_cnt;

    assign w_tmo_hit = (r_state == ACCUM) && (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_tmo_cnt <= '0;
        end else if ((w_next == ACCUM) && ((r_state != ACCUM) || w_coin_acc)) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ACCUM) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
    end
`else
    assign w_tmo_hit = 1'b0;
`endif

    assign bus.coin_ready   = w_coin_ready;
    assign bus.coin_reject  = r_reject;
    assign bus.product      = r_product;
    assign bus.credit       = r_credit;
    assign bus.change_valid = r_change_valid;
    assign bus.change_amt   = r_change_amt;

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed bench for vend_ctrl (PRICE=20, coins 5/10/20, TIMEOUT_CYC=8).
module tb_vend_ctrl;
    import vend_pkg::*;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    vend_ctrl_if #(.CREDIT_W(6)) bus ();

    vend_ctrl #(
        .PRICE(20), .COIN0_VAL(5), .COIN1_VAL(10), .COIN2_VAL(20),
        .CREDIT_W(6), .TIMEOUT_CYC(8)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic coin(input logic v, input logic [1:0] c);
        bus.coin_valid = v;
        bus.coin_code  = c;
    endtask

    initial begin
        bus.coin_valid   = 1'b0;
        bus.coin_code    = COIN_C0;
        bus.cancel       = 1'b0;
        bus.change_ready = 1'b0;

        // Reset state
        repeat (2) tick();
        chk("rst_ready", bus.coin_ready, 0);
        chk("rst_credit", bus.credit, 0);
        chk("rst_product", bus.product, 0);
        chk("rst_cvalid", bus.change_valid, 0);
        chk("rst_camt", bus.change_amt, 0);
        chk("rst_reject", bus.coin_reject, 0);
        sys_rst_n = 1'b1;
        tick();
        chk("post_rst_ready", bus.coin_ready, 1);

        // 1: 5+5+10 exact price
        coin(1, COIN_C0); tick();
        chk("t1_credit5", bus.credit, 5);
        tick();
        chk("t1_credit10", bus.credit, 10);
        coin(1, COIN_C1); tick();
        chk("t1_credit20", bus.credit, 20);
        chk("t1_product", bus.product, 1);
        chk("t1_ready_vend", bus.coin_ready, 0);
        coin(0, COIN_C0); tick();
        chk("t1_product_off", bus.product, 0);
        chk("t1_no_change", bus.change_valid, 0);
        chk("t1_credit0", bus.credit, 0);
        chk("t1_ready_idle", bus.coin_ready, 1);

        // 2: 10+20 with change; coins offered during VEND/CHANGE are ignored
        coin(1, COIN_C1); tick();
        chk("t2_credit10", bus.credit, 10);
        coin(1, COIN_C2); tick();
        chk("t2_product", bus.product, 1);
        coin(1, COIN_C0); tick();
        chk("t2_product_off", bus.product, 0);
        chk("t2_cvalid", bus.change_valid, 1);
        chk("t2_camt", bus.change_amt, 10);
        chk("t2_vend_noreject", bus.coin_reject, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_hold_cvalid", bus.change_valid, 1);
            chk("t2_hold_camt", bus.change_amt, 10);
            chk("t2_hold_noreject", bus.coin_reject, 0);
            chk("t2_hold_credit", bus.credit, 0);
        end
        coin(0, COIN_C0); bus.change_ready = 1'b1; tick();
        chk("t2_cvalid_off", bus.change_valid, 0);
        chk("t2_credit0", bus.credit, 0);
        chk("t2_ready_idle", bus.coin_ready, 1);
        bus.change_ready = 1'b0;

        // 3: cancel refund, then cancel+coin collision
        coin(1, COIN_C0); tick();
        chk("t3_credit5", bus.credit, 5);
        coin(0, COIN_C0); bus.cancel = 1'b1; tick();
        chk("t3_cvalid", bus.change_valid, 1);
        chk("t3_camt", bus.change_amt, 5);
        chk("t3_credit0", bus.credit, 0);
        chk("t3_no_product", bus.product, 0);
        bus.cancel = 1'b0; bus.change_ready = 1'b1; tick();
        chk("t3_cvalid_off", bus.change_valid, 0);
        bus.change_ready = 1'b0;
        coin(1, COIN_C1); tick();
        chk("t3_credit10", bus.credit, 10);
        coin(1, COIN_C2); bus.cancel = 1'b1; tick();
        chk("t3c_reject", bus.coin_reject, 1);
        chk("t3c_cvalid", bus.change_valid, 1);
        chk("t3c_camt", bus.change_amt, 10);
        chk("t3c_credit0", bus.credit, 0);
        coin(0, COIN_C0); bus.cancel = 1'b0; bus.change_ready = 1'b1; tick();
        chk("t3c_reject_off", bus.coin_reject, 0);
        chk("t3c_cvalid_off", bus.change_valid, 0);
        bus.change_ready = 1'b0;
        bus.cancel = 1'b1; tick();
        chk("t3_idle_cancel_ignored", bus.change_valid, 0);
        chk("t3_idle_ready", bus.coin_ready, 1);
        bus.cancel = 1'b0;

        // 4: invalid coin
        coin(1, COIN_INVALID); tick();
        chk("t4_reject", bus.coin_reject, 1);
        chk("t4_credit0", bus.credit, 0);
        coin(0, COIN_C0); tick();
        chk("t4_reject_off", bus.coin_reject, 0);
        coin(1, COIN_C0); tick();
        chk("t4_credit5", bus.credit, 5);
        coin(1, COIN_INVALID); tick();
        chk("t4b_reject", bus.coin_reject, 1);
        chk("t4b_credit5", bus.credit, 5);
        coin(1, COIN_C1); tick();
        chk("t4b_reject_off", bus.coin_reject, 0);
        chk("t4b_credit15", bus.credit, 15);

        // 5: asynchronous reset mid-ACCUM
        coin(0, COIN_C0);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("t5_credit0", bus.credit, 0);
        chk("t5_cvalid", bus.change_valid, 0);
        chk("t5_product", bus.product, 0);
        chk("t5_reject", bus.coin_reject, 0);
        chk("t5_ready", bus.coin_ready, 0);
        tick();
        sys_rst_n = 1'b1;
        tick();
        chk("t5_ready_after", bus.coin_ready, 1);
        chk("t5_credit_after", bus.credit, 0);

        // 6: ACCUM inactivity
        coin(1, COIN_C0); tick();
        chk("t6_credit5", bus.credit, 5);
        coin(0, COIN_C0);
`ifdef VEND_TIMEOUT_EN
        repeat (7) tick();
        chk("t6_not_yet", bus.change_valid, 0);
        tick();
        chk("t6_tmo_cvalid", bus.change_valid, 1);
        chk("t6_tmo_camt", bus.change_amt, 5);
        chk("t6_tmo_credit0", bus.credit, 0);
        bus.change_ready = 1'b1; tick();
        chk("t6_tmo_cvalid_off", bus.change_valid, 0);
        bus.change_ready = 1'b0;
`else
        repeat (100) tick();
        chk("t6_wait_cvalid", bus.change_valid, 0);
        chk("t6_wait_credit", bus.credit, 5);
        chk("t6_wait_ready", bus.coin_ready, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
